// File: rtl/cgra_pe_mc_if.sv
// rtl/cgra_pe_mc_if.sv - configuration, run-control and operand/result bundle for cgra_pe_mc
interface cgra_pe_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CTX    = 8,
    parameter int CW         = $clog2(NUM_CTX)
);
    logic                  cfg_we;
    logic [CW-1:0]         cfg_addr;
    logic [63:0]           cfg_data;
    logic [CW:0]           cfg_ctx_count;
    logic                  start;
    logic                  stop;
    logic [DATA_WIDTH-1:0] data_in_n;
    logic [DATA_WIDTH-1:0] data_in_e;
    logic [DATA_WIDTH-1:0] data_in_s;
    logic [DATA_WIDTH-1:0] data_in_w;
    logic                  valid_in_n;
    logic                  valid_in_e;
    logic                  valid_in_s;
    logic                  valid_in_w;
    logic                  ack_in_n;
    logic                  ack_in_e;
    logic                  ack_in_s;
    logic                  ack_in_w;
    logic [DATA_WIDTH-1:0] data_out;
    logic [4:0]            valid_out;
    logic                  ready_in;
    logic                  busy;
    logic [CW-1:0]         ctx_id;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_ctx_count, start, stop,
        output data_in_n, data_in_e, data_in_s, data_in_w,
        output valid_in_n, valid_in_e, valid_in_s, valid_in_w, ready_in,
        input  ack_in_n, ack_in_e, ack_in_s, ack_in_w,
        input  data_out, valid_out, busy, ctx_id
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_ctx_count, start, stop,
        input  data_in_n, data_in_e, data_in_s, data_in_w,
        input  valid_in_n, valid_in_e, valid_in_s, valid_in_w, ready_in,
        output ack_in_n, ack_in_e, ack_in_s, ack_in_w,
        output data_out, valid_out, busy, ctx_id
    );
endinterface

// File: rtl/cgra_pe_mc.sv
// rtl/cgra_pe_mc.sv - multi-context CGRA processing element with four directional operand inputs
module cgra_pe_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CTX    = 8,
    parameter int CW         = $clog2(NUM_CTX)
) (
    input  logic        clk,
    input  logic        rst_n,
    cgra_pe_mc_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_MUL  = 6'd3;
    localparam logic [5:0] OP_MAC  = 6'd4;
    localparam logic [5:0] OP_CMP  = 6'd5;
    localparam logic [5:0] OP_PASS = 6'd6;

    state_t                state_q, state_d;
    logic [CW-1:0]         ctx_id_q, ctx_id_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [4:0]            valid_out_q, valid_out_d;
    logic [63:0]           ctx_mem_q [NUM_CTX];
    logic [63:0]           ctx_mem_d [NUM_CTX];

    logic [63:0]           frame;
    logic [5:0]            op;
    logic [2:0]            src0, src1;
    logic [4:0]            route;
    logic                  acc_clr;
    logic [DATA_WIDTH-1:0] imm, a, b, acc_eff, res;
    logic [3:0]            vin, need, ack;
    logic                  is_nop, fire, xfer;
    logic [CW:0]           cnt_eff, ctx_inc;
    logic                  unused_frame_parity;

    // Operand selection: 0 imm, 1..4 N/E/S/W, 5 accumulator, 6/7 read zero.
    function automatic logic [DATA_WIDTH-1:0] pick(input logic [2:0] s,
        input logic [DATA_WIDTH-1:0] i, n, e, so, w, ac);
        case (s)
            3'd0:    pick = i;
            3'd1:    pick = n;
            3'd2:    pick = e;
            3'd3:    pick = so;
            3'd4:    pick = w;
            3'd5:    pick = ac;
            default: pick = '0;
        endcase
    endfunction

    // Which directional input (bit0 N .. bit3 W) a source encoding depends on.
    function automatic logic [3:0] dir_of(input logic [2:0] s);
        dir_of = (s >= 3'd1 && s <= 3'd4) ? (4'b0001 << (s - 3'd1)) : 4'b0000;
    endfunction

    assign frame   = ctx_mem_q[ctx_id_q];
    assign op      = frame[5:0];
    assign src0    = frame[8:6];
    assign src1    = frame[11:9];
    assign route   = frame[16:12];
    assign acc_clr = frame[17];
    assign imm     = frame[32 +: DATA_WIDTH];
    assign unused_frame_parity = ^frame;

    // Fire decision, datapath, run-control FSM and all next-state values.
    always_comb begin
        state_d     = state_q;
        ctx_id_d    = ctx_id_q;
        acc_d       = acc_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        ctx_mem_d   = ctx_mem_q;
        ack         = 4'b0000;
        res         = '0;

        vin     = {bus.valid_in_w, bus.valid_in_s, bus.valid_in_e, bus.valid_in_n};
        acc_eff = acc_clr ? '0 : acc_q;
        a = pick(src0, imm, bus.data_in_n, bus.data_in_e, bus.data_in_s, bus.data_in_w, acc_eff);
        b = pick(src1, imm, bus.data_in_n, bus.data_in_e, bus.data_in_s, bus.data_in_w, acc_eff);
        need   = dir_of(src0) | dir_of(src1);
        is_nop = (op == 6'd0) || (op > OP_PASS);
        xfer   = (valid_out_q != 5'd0) && bus.ready_in;
        fire   = (state_q == RUN) &&
                 (is_nop || ((&(vin | ~need)) && ((valid_out_q == 5'd0) || bus.ready_in)));

        // Out-of-range context counts are clamped so ctx_id always stays in bounds.
        if (bus.cfg_ctx_count == '0)
            cnt_eff = (CW+1)'(1);
        else if (bus.cfg_ctx_count > (CW+1)'(NUM_CTX))
            cnt_eff = (CW+1)'(NUM_CTX);
        else
            cnt_eff = bus.cfg_ctx_count;
        ctx_inc = {1'b0, ctx_id_q} + (CW+1)'(1);

        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = a * b;
            OP_MAC:  res = acc_eff + a * b;
            OP_CMP:  res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_PASS: res = a;
            default: res = '0;
        endcase

        if (xfer) begin
            data_out_d  = '0;
            valid_out_d = 5'd0;
        end

        if (fire) begin
            ctx_id_d = (ctx_inc >= cnt_eff) ? '0 : ctx_inc[CW-1:0];
            if (!is_nop) begin
                ack         = need;
                data_out_d  = res;
                valid_out_d = route;
                if (op == OP_MAC)
                    acc_d = res;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    ctx_id_d = '0;
                end
                if (bus.cfg_we)
                    ctx_mem_d[bus.cfg_addr] = bus.cfg_data;
            end
            default: begin
                if (bus.stop)
                    state_d = IDLE;
            end
        endcase
    end

    // State register; reset wipes every context back to NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctx_id_q    <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 5'd0;
            for (int i = 0; i < NUM_CTX; i++)
                ctx_mem_q[i] <= 64'd0;
        end else begin
            state_q     <= state_d;
            ctx_id_q    <= ctx_id_d;
            acc_q       <= acc_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            ctx_mem_q   <= ctx_mem_d;
        end
    end

    assign bus.ack_in_n  = ack[0];
    assign bus.ack_in_e  = ack[1];
    assign bus.ack_in_s  = ack[2];
    assign bus.ack_in_w  = ack[3];
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.ctx_id    = ctx_id_q;
endmodule

// File: tb/tb_cgra_pe_mc.sv
// tb/tb_cgra_pe_mc.sv - directed and randomized self-checking bench for cgra_pe_mc
module tb_cgra_pe_mc;
    localparam int DW = 16;
    localparam int NC = 8;
    localparam int CWL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    cgra_pe_mc_if #(.DATA_WIDTH(DW), .NUM_CTX(NC), .CW(CWL)) bus ();

    cgra_pe_mc #(.DATA_WIDTH(DW), .NUM_CTX(NC), .CW(CWL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input int op, input int s0, input int s1,
                                       input int route, input int clr, input int imm);
        logic [63:0] f;
        f = 64'd0;
        f[5:0]   = 6'(op);
        f[8:6]   = 3'(s0);
        f[11:9]  = 3'(s1);
        f[16:12] = 5'(route);
        f[17]    = 1'(clr);
        f[63:32] = 32'(imm);
        return f;
    endfunction

    task automatic cfg(input int addr, input logic [63:0] f);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(addr);
        bus.cfg_data = f;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_ne(input int n, input int e, input logic vn, input logic ve);
        bus.data_in_n  = 16'(n);
        bus.data_in_e  = 16'(e);
        bus.valid_in_n = vn;
        bus.valid_in_e = ve;
    endtask

    // Reference behaviour of one ALU operation, plain integer arithmetic mod 2^16.
    function automatic longint model_op(input int op, input longint a, input longint b,
                                        inout longint acc, input int clr);
        longint sa, sb, base;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        base = clr ? 0 : acc;
        case (op)
            1: return (a + b) % 65536;
            2: return (a - b + 65536) % 65536;
            3: return (a * b) % 65536;
            4: begin acc = (base + a * b) % 65536; return acc; end
            5: return (sa > sb) ? 1 : 0;
            default: return a;
        endcase
    endfunction

    initial begin
        longint m_acc;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0; bus.cfg_ctx_count = 1;
        bus.start = 0; bus.stop = 0; bus.ready_in = 0;
        bus.data_in_n = 0; bus.data_in_e = 0; bus.data_in_s = 0; bus.data_in_w = 0;
        bus.valid_in_n = 0; bus.valid_in_e = 0; bus.valid_in_s = 0; bus.valid_in_w = 0;
        #2;
        check("rst_data_out", 64'(bus.data_out), 0);
        check("rst_valid_out", 64'(bus.valid_out), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_ctx_id", 64'(bus.ctx_id), 0);
        do_reset();

        // ADD imm + N routed local
        cfg(0, mk(1, 0, 1, 5'b10000, 0, 10));
        bus.cfg_ctx_count = 1;
        pulse_start();
        check("add_busy", 64'(bus.busy), 1);
        drive_ne(20, 0, 1, 0);
        #1;
        check("add_ack_n", 64'(bus.ack_in_n), 1);
        tick();
        drive_ne(0, 0, 0, 0);
        #1;
        check("add_data", 64'(bus.data_out), 30);
        check("add_valid", 64'(bus.valid_out), 64'b10000);
        check("add_ack_once", 64'(bus.ack_in_n), 0);
        bus.ready_in = 1;
        pulse_stop();
        check("add_idle", 64'(bus.busy), 0);

        // MAC chain over two contexts
        do_reset();
        cfg(0, mk(4, 1, 2, 5'b10000, 1, 0));
        cfg(1, mk(4, 1, 2, 5'b10000, 0, 0));
        bus.cfg_ctx_count = 2;
        bus.ready_in = 1;
        pulse_start();
        check("mac_ctx0", 64'(bus.ctx_id), 0);
        drive_ne(2, 3, 1, 1);
        #1;
        check("mac_acks", 64'({bus.ack_in_n, bus.ack_in_e}), 64'b11);
        tick();
        check("mac_r0", 64'(bus.data_out), 6);
        check("mac_ctx1", 64'(bus.ctx_id), 1);
        drive_ne(4, 5, 1, 1);
        tick();
        drive_ne(0, 0, 0, 0);
        #1;
        check("mac_r1", 64'(bus.data_out), 26);
        check("mac_ctx_wrap", 64'(bus.ctx_id), 0);
        tick();
        check("mac_clear_valid", 64'(bus.valid_out), 0);
        check("mac_clear_data", 64'(bus.data_out), 0);
        pulse_stop();

        // PASS0 with backpressure
        do_reset();
        cfg(0, mk(6, 0, 0, 5'b01111, 0, 16'hABCD));
        cfg(1, mk(6, 0, 0, 5'b01111, 0, 16'h1234));
        bus.cfg_ctx_count = 2;
        bus.ready_in = 0;
        pulse_start();
        check("pass_empty", 64'(bus.valid_out), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("pass_hold_data", 64'(bus.data_out), 64'hABCD);
            check("pass_hold_valid", 64'(bus.valid_out), 64'b01111);
            check("pass_hold_ctx", 64'(bus.ctx_id), 1);
            tick();
        end
        bus.ready_in = 1;
        tick();
        check("pass_next_data", 64'(bus.data_out), 64'h1234);
        check("pass_next_ctx", 64'(bus.ctx_id), 0);
        pulse_stop();

        // CMP_GT signed and missing operand
        do_reset();
        cfg(0, mk(5, 1, 2, 5'b10000, 0, 0));
        cfg(1, mk(5, 1, 2, 5'b10000, 0, 0));
        bus.cfg_ctx_count = 2;
        bus.ready_in = 1;
        pulse_start();
        drive_ne(16'hFFFF, 5, 1, 1);
        tick();
        check("cmp_neg_data", 64'(bus.data_out), 0);
        check("cmp_neg_valid", 64'(bus.valid_out), 64'b10000);
        drive_ne(7, 5, 1, 1);
        tick();
        check("cmp_pos_data", 64'(bus.data_out), 1);
        drive_ne(7, 5, 1, 0);
        #1;
        check("cmp_miss_ack", 64'({bus.ack_in_n, bus.ack_in_e}), 0);
        tick();
        check("cmp_miss_ctx", 64'(bus.ctx_id), 0);
        check("cmp_miss_valid", 64'(bus.valid_out), 0);
        drive_ne(0, 0, 0, 0);
        pulse_stop();

        // MUL wrap, cfg ignored in RUN, reset mid-RUN
        do_reset();
        cfg(0, mk(3, 1, 2, 5'b10000, 0, 0));
        bus.cfg_ctx_count = 1;
        bus.ready_in = 1;
        pulse_start();
        drive_ne(16'h0100, 16'h0100, 1, 1);
        tick();
        drive_ne(0, 0, 0, 0);
        check("mul_wrap_data", 64'(bus.data_out), 0);
        check("mul_wrap_valid", 64'(bus.valid_out), 64'b10000);
        cfg(0, mk(6, 0, 0, 5'b10000, 0, 16'h55));
        bus.ready_in = 0;
        drive_ne(3, 4, 1, 1);
        tick();
        drive_ne(0, 0, 0, 0);
        check("cfg_in_run_ignored", 64'(bus.data_out), 12);
        rst_n = 1'b0;
        #1;
        check("rst_mid_data", 64'(bus.data_out), 0);
        check("rst_mid_valid", 64'(bus.valid_out), 0);
        check("rst_mid_busy", 64'(bus.busy), 0);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_stay_idle", 64'(bus.busy), 0);

        // Randomized single-context operations against the reference model
        do_reset();
        m_acc = 0;
        bus.cfg_ctx_count = 1;
        bus.ready_in = 1;
        for (int it = 0; it < 24; it++) begin
            int op, s0, clr, imm, n, e;
            longint a, exp;
            op  = $urandom_range(6, 1);
            s0  = $urandom_range(1, 0);
            clr = $urandom_range(1, 0);
            imm = $urandom_range(65535, 0);
            n   = $urandom_range(65535, 0);
            e   = $urandom_range(65535, 0);
            cfg(0, mk(op, s0, 2, 5'b00101, clr, imm));
            pulse_start();
            drive_ne(n, e, 1, 1);
            tick();
            drive_ne(0, 0, 0, 0);
            a = (s0 == 0) ? longint'(imm) : longint'(n);
            exp = model_op(op, a, longint'(e), m_acc, clr);
            check("rand_data", 64'(bus.data_out), 64'(exp));
            check("rand_valid", 64'(bus.valid_out), 64'b00101);
            pulse_stop();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/cgra_pe_mc.md
CGRA_PE_MC -- requirements
Module: cgra_pe_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, datapath width, legal range 8..32.
REQ-002 The block SHALL have parameter NUM_CTX, default 8, number of stored configuration contexts, power of two, at least 2.
REQ-003 The block SHALL have parameter CW, default $clog2(NUM_CTX), context index width.
REQ-004 The block SHALL have the port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-006 The block SHALL have the ports cfg_we (input, 1), cfg_addr (input, CW) and cfg_data (input, 64): a context write port.
REQ-007 The block SHALL have the port cfg_ctx_count, input, CW+1 bits, number of active contexts; 0 is treated as 1, and values above NUM_CTX are treated as NUM_CTX.
REQ-008 The block SHALL have the ports start and stop, inputs, 1 bit each, single-cycle run-control pulses.
REQ-009 The block SHALL have the ports data_in_n/e/s/w (input, DATA_WIDTH each) and valid_in_n/e/s/w (input, 1 each): the directional operands.
REQ-010 The block SHALL have the ports ack_in_n/e/s/w, output, 1 bit each, which pulse in the cycle the matching operand is consumed.
REQ-011 The block SHALL have the port data_out, output, DATA_WIDTH bits, the registered result.
REQ-012 The block SHALL have the port valid_out, output, 5 bits, a per-destination valid mask: bit0 N, bit1 E, bit2 S, bit3 W, bit4 local.
REQ-013 The block SHALL have the port ready_in, input, 1 bit, the downstream accept signal, shared by all destinations.
REQ-014 The block SHALL have the ports busy (output, 1, high in RUN) and ctx_id (output, CW, the current context).

Function
REQ-015 The context frame SHALL be laid out as follows: [5:0] op, [8:6] src0, [11:9] src1, [16:12] route mask, [17] acc_clr, [63:32] imm; the low DATA_WIDTH bits of imm are used.
REQ-016 The src encodings SHALL be: 0 imm, 1 N, 2 E, 3 S, 4 W, 5 acc; encodings 6 and 7 read 0.
REQ-017 The op encodings SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 MUL (low DATA_WIDTH bits of the product), 4 MAC (acc<=acc+a*b, result is the new acc), 5 CMP_GT (signed, result 1 or 0), 6 PASS0 (result a); all other codes behave as NOP.
REQ-018 All arithmetic SHALL wrap modulo 2^DATA_WIDTH, with no saturation.
REQ-019 The FSM SHALL have two states, IDLE and RUN; start in IDLE moves to RUN with ctx_id=0; stop in RUN moves to IDLE next cycle; start in RUN and stop in IDLE are ignored.
REQ-020 A cfg_we write SHALL take effect only in IDLE; in RUN it is ignored.
REQ-021 In RUN, the current context SHALL fire when every directional source it selects has valid high, and the output register is empty or is transferring (valid_out!=0 and ready_in) in the same cycle.
REQ-022 NOP SHALL fire unconditionally, produce no output and consume no operands.
REQ-023 On a fire, the block SHALL combinationally assert ack_in for each selected direction, once even if both src0 and src1 select it.
REQ-024 On a fire, the block SHALL load data_out with the result and valid_out with the route mask on the next edge.
REQ-025 On a fire, ctx_id SHALL increment on the next edge and wrap from cfg_ctx_count-1 to 0.
REQ-026 A route mask of 0 SHALL compute the result (MAC updates acc) but produce no output valid.
REQ-027 If acc_clr=1, acc SHALL be treated as 0 before the op; for MAC this gives acc<=a*b.
REQ-028 Output hold: data_out and valid_out SHALL stay stable while valid_out!=0 and ready_in=0, and clear to 0 on transfer unless a new fire reloads them.
REQ-029 A stop with a result pending SHALL leave that output valid until it is accepted; no further fires occur.
REQ-030 stop and a fire in the same cycle SHALL complete the fire, then enter IDLE.

Reset
REQ-031 When rst_n is low, the block SHALL immediately set state IDLE, ctx_id=0, acc=0, data_out=0, valid_out=0, ack_in all 0, busy=0, and all contexts to 0 (NOP).
REQ-032 Reset asserted mid-RUN SHALL discard any pending output; after release, the block stays IDLE until start.

Verification
REQ-033 The bench SHALL cover: ctx0 ADD imm=10, src1=N, N=20 valid, route=local -> one cycle after fire, data_out=30, valid_out=5'b10000, ack_in_n pulsed once.
REQ-034 The bench SHALL cover: cfg_ctx_count=2, ctx0 MAC(N,E) with acc_clr, ctx1 MAC(N,E); supply (2,3) then (4,5) -> results 6 then 26; ctx_id sequence 0,1,0.
REQ-035 The bench SHALL cover: PASS0 imm=16'hABCD, route=5'b01111, ready_in=0 for 3 cycles -> output held at ABCD/01111 with no new fire; ready_in=1 -> transfer, next fire allowed.
REQ-036 The bench SHALL cover: CMP_GT with src0=N=-1 and src1=E=5 -> 0; with N=7 and E=5 -> 1; operand missing valid -> no fire, no ack, ctx_id held.
REQ-037 The bench SHALL cover: MUL 16'h0100*16'h0100 -> 0 (wrap); cfg_we during RUN -> context unchanged; rst_n low mid-RUN -> all outputs 0 immediately, IDLE.
